// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: N execute pipes share one writeback port.
// Define BLIMP_WB_ARB_OUTPUT_REG_EN for a registered output stage (latency 1).
module wb_arbiter #(
    parameter int p_num_pipes      = 3,
    parameter int p_seq_num_bits   = 5,
    parameter int p_phys_addr_bits = 6
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [p_num_pipes-1:0]                    ex_val,
    output logic [p_num_pipes-1:0]                    ex_rdy,
    input  logic [p_num_pipes*p_seq_num_bits-1:0]     ex_seq_num,
    input  logic [p_num_pipes*5-1:0]                  ex_waddr,
    input  logic [p_num_pipes*p_phys_addr_bits-1:0]   ex_preg,
    input  logic [p_num_pipes*32-1:0]                 ex_wdata,
    input  logic [p_num_pipes-1:0]                    ex_wen,
    output logic                                      w_val,
    input  logic                                      w_rdy,
    output logic [p_seq_num_bits-1:0]                 w_seq_num,
    output logic [4:0]                                w_waddr,
    output logic [p_phys_addr_bits-1:0]               w_preg,
    output logic [31:0]                               w_wdata,
    output logic                                      w_wen,
    output logic [$clog2(p_num_pipes)-1:0]            w_pipe
);

    localparam int PW = $clog2(p_num_pipes);

    logic [PW-1:0] ptr;
    logic [PW-1:0] lock_pipe;
    logic          lock_vld;
    logic [PW-1:0] rr_pick;
    logic          rr_any;
    int            rr_idx;
    logic [PW-1:0] sel;
    logic [PW-1:0] nxt_ptr;
    logic          in_val;
    logic          in_rdy;
    logic          xfer;

    logic [p_seq_num_bits-1:0]   sel_seq;
    logic [4:0]                  sel_waddr;
    logic [p_phys_addr_bits-1:0] sel_preg;
    logic [31:0]                 sel_wdata;
    logic                        sel_wen;

    // First valid pipe at or after ptr, wrapping around.
    always_comb begin
        rr_pick = '0;
        rr_any  = 1'b0;
        rr_idx  = 0;
        for (int k = 0; k < p_num_pipes; k++) begin
            rr_idx = (int'(ptr) + k) % p_num_pipes;
            if (!rr_any && ex_val[rr_idx]) begin
                rr_any  = 1'b1;
                rr_pick = PW'(rr_idx);
            end
        end
    end

    // A stalled grant stays with its pipe so higher priority can't preempt.
    assign sel    = lock_vld ? lock_pipe : rr_pick;
    assign in_val = lock_vld ? ex_val[lock_pipe] : rr_any;
    assign xfer   = in_val & in_rdy & ~rst;

    assign nxt_ptr = (sel == PW'(p_num_pipes - 1)) ? '0 : sel + PW'(1);

    assign sel_seq   = ex_seq_num[sel*p_seq_num_bits +: p_seq_num_bits];
    assign sel_waddr = ex_waddr[sel*5 +: 5];
    assign sel_preg  = ex_preg[sel*p_phys_addr_bits +: p_phys_addr_bits];
    assign sel_wdata = ex_wdata[sel*32 +: 32];
    assign sel_wen   = ex_wen[sel];

    always_comb begin
        ex_rdy = '0;
        if (in_val && !rst) begin
            ex_rdy[sel] = in_rdy;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            lock_vld  <= 1'b0;
            lock_pipe <= '0;
        end else begin
            lock_vld  <= in_val & ~in_rdy;
            lock_pipe <= sel;
            if (xfer) begin
                ptr <= nxt_ptr;
            end
        end
    end

`ifdef BLIMP_WB_ARB_OUTPUT_REG_EN

    assign in_rdy = ~w_val | w_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_val     <= 1'b0;
            w_pipe    <= '0;
            w_seq_num <= '0;
            w_waddr   <= '0;
            w_preg    <= '0;
            w_wdata   <= '0;
            w_wen     <= 1'b0;
        end else if (xfer) begin
            w_val     <= 1'b1;
            w_pipe    <= sel;
            w_seq_num <= sel_seq;
            w_waddr   <= sel_waddr;
            w_preg    <= sel_preg;
            w_wdata   <= sel_wdata;
            w_wen     <= sel_wen;
        end else if (w_rdy) begin
            w_val     <= 1'b0;
            w_pipe    <= '0;
            w_seq_num <= '0;
            w_waddr   <= '0;
            w_preg    <= '0;
            w_wdata   <= '0;
            w_wen     <= 1'b0;
        end
    end

`else

    assign in_rdy = w_rdy;

    // Idle or in reset, every output field reads as zero.
    always_comb begin
        w_val     = in_val & ~rst;
        w_pipe    = w_val ? sel : '0;
        w_seq_num = w_val ? sel_seq : '0;
        w_waddr   = w_val ? sel_waddr : '0;
        w_preg    = w_val ? sel_preg : '0;
        w_wdata   = w_val ? sel_wdata : '0;
        w_wen     = w_val & sel_wen;
    end

`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: per-pipe source queues feed the DUT,
// a negedge monitor pops expected results on every writeback transfer.
module tb_wb_arbiter;

    localparam int NP = 3;
    localparam int SB = 5;
    localparam int AB = 6;
    localparam int PW = 2;
`ifdef BLIMP_WB_ARB_OUTPUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    ex_val;
    logic [NP-1:0]    ex_rdy;
    logic [NP*SB-1:0] ex_seq_num;
    logic [NP*5-1:0]  ex_waddr;
    logic [NP*AB-1:0] ex_preg;
    logic [NP*32-1:0] ex_wdata;
    logic [NP-1:0]    ex_wen;
    logic             w_val;
    logic             w_rdy;
    logic [SB-1:0]    w_seq_num;
    logic [4:0]       w_waddr;
    logic [AB-1:0]    w_preg;
    logic [31:0]      w_wdata;
    logic             w_wen;
    logic [PW-1:0]    w_pipe;

    always #5 clk = ~clk;

    wb_arbiter #(
        .p_num_pipes(NP),
        .p_seq_num_bits(SB),
        .p_phys_addr_bits(AB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ex_val(ex_val),
        .ex_rdy(ex_rdy),
        .ex_seq_num(ex_seq_num),
        .ex_waddr(ex_waddr),
        .ex_preg(ex_preg),
        .ex_wdata(ex_wdata),
        .ex_wen(ex_wen),
        .w_val(w_val),
        .w_rdy(w_rdy),
        .w_seq_num(w_seq_num),
        .w_waddr(w_waddr),
        .w_preg(w_preg),
        .w_wdata(w_wdata),
        .w_wen(w_wen),
        .w_pipe(w_pipe)
    );

    typedef struct {
        logic [SB-1:0] seq;
        logic [4:0]    waddr;
        logic [AB-1:0] preg;
        logic [31:0]   wdata;
        logic          wen;
    } item_t;

    typedef struct {
        int    pipe;
        item_t it;
    } exp_t;

    item_t         src_q[NP][$];
    exp_t          exp_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [NP-1:0] hs = '0;
    int            n;

    function automatic item_t mk(input logic [SB-1:0] seq,
                                 input logic [4:0] waddr,
                                 input logic [AB-1:0] preg,
                                 input logic [31:0] wdata,
                                 input logic wen);
        item_t t;
        t.seq   = seq;
        t.waddr = waddr;
        t.preg  = preg;
        t.wdata = wdata;
        t.wen   = wen;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue a result on pipe p and record where it must come out.
    task automatic issue(input int p, input item_t t);
        exp_t e;
        src_q[p].push_back(t);
        e.pipe = p;
        e.it   = t;
        exp_q.push_back(e);
    endtask

    task automatic refresh();
        ex_val     = '0;
        ex_seq_num = '0;
        ex_waddr   = '0;
        ex_preg    = '0;
        ex_wdata   = '0;
        ex_wen     = '0;
        for (int i = 0; i < NP; i++) begin
            if (src_q[i].size() != 0) begin
                ex_val[i]            = 1'b1;
                ex_seq_num[i*SB +: SB] = src_q[i][0].seq;
                ex_waddr[i*5 +: 5]   = src_q[i][0].waddr;
                ex_preg[i*AB +: AB]  = src_q[i][0].preg;
                ex_wdata[i*32 +: 32] = src_q[i][0].wdata;
                ex_wen[i]            = src_q[i][0].wen;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (hs[i]) void'(src_q[i].pop_front());
        end
        refresh();
        #1;
    endtask

    task automatic clear_src();
        for (int i = 0; i < NP; i++) src_q[i].delete();
    endtask

    task automatic drain(input string name, input int max, output int cnt);
        cnt = 0;
        while (exp_q.size() != 0 && cnt < max) begin
            cyc();
            cnt++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: drain timeout, %0d results left, want 0",
                     name, exp_q.size());
            exp_q.delete();
            clear_src();
            refresh();
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_w_val"}, 32'(w_val), 0);
        chk({name, "_ex_rdy"}, 32'(ex_rdy), 0);
        chk({name, "_w_pipe"}, 32'(w_pipe), 0);
        chk({name, "_w_wdata"}, w_wdata, 0);
        chk({name, "_w_seq"}, 32'(w_seq_num), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        hs = ex_val & ex_rdy;
        if (!rst) begin
            chk("rdy_onehot0", 32'($onehot0(ex_rdy)), 1);
            chk("rdy_within_val", 32'(ex_rdy & ~ex_val), 0);
        end
        if (w_val && w_rdy) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_xfer: got pipe %0d seq %0h, want none",
                         w_pipe, w_seq_num);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pipe", 32'(w_pipe), 32'(e.pipe));
                chk("sb_seq", 32'(w_seq_num), 32'(e.it.seq));
                chk("sb_waddr", 32'(w_waddr), 32'(e.it.waddr));
                chk("sb_preg", 32'(w_preg), 32'(e.it.preg));
                chk("sb_wdata", w_wdata, e.it.wdata);
                chk("sb_wen", 32'(w_wen), 32'(e.it.wen));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        w_rdy = 1'b1;
        refresh();
        repeat (3) cyc();
        chk_idle("reset");

        // A pipe valid during reset must be ignored.
        src_q[2].push_back(mk(5'd1, 5'd1, 6'd1, 32'h1111_1111, 1'b1));
        refresh();
        #1;
        chk_idle("reset_val");
        clear_src();
        refresh();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc();
        chk_idle("post_reset");

        // All three pipes valid: order 0,1,2,0 at one transfer per cycle.
        issue(0, mk(5'd3, 5'd1, 6'd10, 32'h0000_0A03, 1'b1));
        issue(1, mk(5'd7, 5'd2, 6'd11, 32'h0000_0B07, 1'b1));
        issue(2, mk(5'd9, 5'd3, 6'd12, 32'h0000_0C09, 1'b0));
        issue(0, mk(5'd11, 5'd4, 6'd13, 32'h0000_0A0B, 1'b1));
        refresh();
        drain("rr_all", 20, n);
        chk("rr_cycles", 32'(n), 32'(4 + LAT));

        // Lone pipe 2 passes exactly; ptr wraps to 0.
        issue(2, mk(5'd5, 5'd17, 6'd12, 32'hDEAD_BEEF, 1'b1));
        refresh();
        drain("lone2", 10, n);
        issue(0, mk(5'd20, 5'd5, 6'd20, 32'h0000_2000, 1'b1));
        issue(1, mk(5'd21, 5'd6, 6'd21, 32'h0000_2100, 1'b0));
        refresh();
        drain("wrap", 10, n);

        // Stalled grant on pipe 1 must not be preempted by pipe 0.
        w_rdy = 1'b0;
        issue(1, mk(5'd13, 5'd7, 6'd30, 32'hCAFE_0001, 1'b1));
        refresh();
        cyc();
        issue(0, mk(5'd14, 5'd8, 6'd31, 32'hCAFE_0000, 1'b1));
        refresh();
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_w_val", 32'(w_val), 1);
            chk("stall_w_pipe", 32'(w_pipe), 1);
            chk("stall_wdata", w_wdata, 32'hCAFE_0001);
            chk("stall_ex_rdy", 32'(ex_rdy), 0);
        end
        w_rdy = 1'b1;
        drain("stall_release", 10, n);

        // Pipe 0 streaming, pipe 1 joins once: serviced on second transfer.
        issue(0, mk(5'd16, 5'd9, 6'd40, 32'h0000_4000, 1'b1));
        refresh();
        cyc();
        issue(1, mk(5'd17, 5'd10, 6'd41, 32'h0000_4100, 1'b1));
        issue(0, mk(5'd18, 5'd11, 6'd42, 32'h0000_4001, 1'b1));
        issue(0, mk(5'd19, 5'd12, 6'd43, 32'h0000_4002, 1'b1));
        refresh();
        drain("fair", 20, n);

        // Reset during a stall discards the held result.
        w_rdy = 1'b0;
        src_q[1].push_back(mk(5'd22, 5'd13, 6'd50, 32'h0000_5000, 1'b1));
        refresh();
        cyc();
        cyc();
        chk("pre_rst_w_val", 32'(w_val), 1);
        rst = 1'b1;
        clear_src();
        refresh();
        cyc();
        chk_idle("mid_stall_rst");
        rst = 1'b0;
        w_rdy = 1'b1;
        cyc();
        chk_idle("idle");

        // Pointer back at 0: pipe 0 ahead of pipe 2.
        issue(0, mk(5'd24, 5'd14, 6'd60, 32'h0000_6000, 1'b1));
        issue(2, mk(5'd25, 5'd15, 6'd61, 32'h0000_6002, 1'b1));
        refresh();
        drain("ptr_reset", 10, n);

        repeat (3) cyc();
        chk("exp_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter p_num_pipes, default 3; number of execute pipes sharing the writeback port.
REQ-002 Parameter p_seq_num_bits, default 5; width of the in-flight sequence number.
REQ-003 Parameter p_phys_addr_bits, default 6; width of the physical destination register.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 ex_val  in  p_num_pipes  per-pipe result valid.
REQ-007 ex_rdy  out  p_num_pipes  per-pipe result accepted.
REQ-008 ex_seq_num  in  p_num_pipes*p_seq_num_bits  per-pipe sequence number, pipe i at slice i.
REQ-009 ex_waddr  in  p_num_pipes*5  per-pipe architectural destination.
REQ-010 ex_preg  in  p_num_pipes*p_phys_addr_bits  per-pipe physical destination.
REQ-011 ex_wdata  in  p_num_pipes*32  per-pipe result data.
REQ-012 ex_wen  in  p_num_pipes  per-pipe register-write enable.
REQ-013 w_val  out  1  writeback valid.
REQ-014 w_rdy  in  1  writeback ready.
REQ-015 w_seq_num / w_waddr / w_preg / w_wdata / w_wen  out  p_seq_num_bits / 5 / p_phys_addr_bits / 32 / 1  granted pipe's fields.
REQ-016 w_pipe  out  $clog2(p_num_pipes)  index of the pipe supplying the current output.

Function
REQ-017 Transfer on any port SHALL occur only in a cycle where its val and rdy are both high.
REQ-018 Arbitration SHALL be round-robin: scan from priority pointer ptr upward with wrap at p_num_pipes-1 -> 0; first pipe with ex_val high is granted.
REQ-019 At most one ex_rdy bit SHALL be high in any cycle, and only for the granted pipe.
REQ-020 After a transfer from pipe g, ptr SHALL become (g+1) mod p_num_pipes on the next edge; otherwise ptr holds.
REQ-021 While the output is valid and stalled (w_val & ~w_rdy), the grant SHALL be locked to the same pipe; a newly valid higher-priority pipe SHALL NOT preempt it.
REQ-022 No ex_val high: ex_rdy all zero, w_val low, ptr unchanged.
REQ-023 Data fields SHALL pass unmodified; ex_wen=0 results still transfer with w_wen=0.
REQ-024 An asserted ex_val is never dropped; its pipe is granted within p_num_pipes transfers.

Reset
REQ-025 rst high on an edge: ptr=0, grant lock cleared, output register (if present) invalid.
REQ-026 During and after reset until new valid input: w_val=0, ex_rdy=0, w_pipe=0, all w_ data fields 0.
REQ-027 Reset mid-stall SHALL discard any held output; no transfer is reported for that cycle.

Configuration
REQ-028 Macro BLIMP_WB_ARB_OUTPUT_REG_EN SHALL select the output-stage variant.
REQ-029 Undefined: combinational path, zero latency; ex_rdy[g] = grant[g] & w_rdy; w_ fields driven from granted pipe in the same cycle.
REQ-030 Defined: one-entry pipeline register, latency 1; ex_rdy[g] = grant[g] & (~w_val | w_rdy); register loads on input transfer, clears when w_rdy with no new transfer; full throughput of one result per cycle under constant w_rdy.

Verification
REQ-031 Reset then pipes 0,1,2 all valid, w_rdy=1 -> output order 0,1,2,0 (seq 3,7,9 then next); one transfer per cycle.
REQ-032 Only pipe 2 valid with seq 5, wdata 0xDEADBEEF, preg 12, w_rdy=1 -> w_val=1, w_pipe=2, fields match exactly; ptr becomes 0.
REQ-033 Pipe 1 granted, w_rdy=0 for 3 cycles, pipe 0 asserts meanwhile -> w_pipe stays 1, data stable, ex_rdy[0]=0; pipe 0 follows after w_rdy=1.
REQ-034 Pipe 0 valid continuously, pipe 1 valid once -> pipe 1 granted no later than second transfer.
REQ-035 rst asserted during REQ-033 stall -> next cycle w_val=0, ptr=0, no transfer reported.
REQ-036 With BLIMP_WB_ARB_OUTPUT_REG_EN: pipe 0 valid at cycle 1 -> w_val rises cycle 2; back-to-back inputs under w_rdy=1 give w_val high every cycle.
